// File: rtl/photocell_rx.sv
// rtl/photocell_rx.sv - photocell synchronizer, debouncer and passage detector
// Two identical beam channels feed full/empty-gated enter/leave pulses.
module photocell_rx #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_MAX       = 1000
) (
  input  logic       FPGA_clk,
  input  logic       reset,
  input  logic       phcOne,
  input  logic       phcTwo,
  input  logic       full,
  input  logic       empty,
  output logic       enter_pulse,
  output logic       leave_pulse,
  output logic       blocked1,
  output logic       blocked2,
  output logic       stuck1,
  output logic       stuck2,
  output logic [3:0] rejects
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BLOCKED = 1'b1} state_t;

  localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [16:0] STK_LIMIT = 17'(STUCK_MAX);

  logic [SYNC_STAGES-1:0] r_sync [2];
  state_t                 r_state [2];
  logic [7:0]             r_deb [2];
  logic [15:0]            r_stk [2];
  logic [1:0]             r_blocked;
  logic [1:0]             r_stuck;
  logic [1:0]             r_ev;
  logic                   r_enter;
  logic                   r_leave;
  logic [3:0]             r_rejects;
  logic [1:0]             w_raw;
  logic [1:0]             w_s;

  assign w_raw = {phcTwo, phcOne};
  assign w_s   = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};

  always_ff @(posedge FPGA_clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        r_sync[c]  <= '1;
        r_state[c] <= ST_IDLE;
        r_deb[c]   <= '0;
        r_stk[c]   <= '0;
      end
      r_blocked <= '0;
      r_stuck   <= '0;
      r_ev      <= '0;
      r_enter   <= 1'b0;
      r_leave   <= 1'b0;
      r_rejects <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], w_raw[c]};
        r_ev[c]   <= 1'b0;
        case (r_state[c])
          ST_IDLE: begin
            if (!w_s[c]) begin
              if (r_deb[c] == DEB_LAST) begin
                r_state[c]   <= ST_BLOCKED;
                r_blocked[c] <= 1'b1;
                r_deb[c]     <= '0;
              end else begin
                r_deb[c] <= r_deb[c] + 8'd1;
              end
            end else begin
              r_deb[c] <= '0;
            end
          end
          ST_BLOCKED: begin
            if (r_stk[c] != STK_LIMIT[15:0]) r_stk[c] <= r_stk[c] + 16'd1;
            if ({1'b0, r_stk[c]} + 17'd1 >= STK_LIMIT) r_stuck[c] <= 1'b1;
            if (w_s[c]) begin
              // release completes: the later clears override the stuck update above
              if (r_deb[c] == DEB_LAST) begin
                r_state[c]   <= ST_IDLE;
                r_blocked[c] <= 1'b0;
                r_stuck[c]   <= 1'b0;
                r_stk[c]     <= '0;
                r_deb[c]     <= '0;
                r_ev[c]      <= 1'b1;
              end else begin
                r_deb[c] <= r_deb[c] + 8'd1;
              end
            end else begin
              r_deb[c] <= '0;
            end
          end
          default: r_state[c] <= ST_IDLE;
        endcase
      end

      r_enter <= 1'b0;
      r_leave <= 1'b0;
      if (r_ev[0] && r_ev[1]) begin
        r_enter <= 1'b1;
        r_leave <= 1'b1;
      end else if (r_ev[0]) begin
        if (!full) r_enter <= 1'b1;
        else if (r_rejects != 4'hF) r_rejects <= r_rejects + 4'd1;
      end else if (r_ev[1]) begin
        if (!empty) r_leave <= 1'b1;
        else if (r_rejects != 4'hF) r_rejects <= r_rejects + 4'd1;
      end
    end
  end

  assign enter_pulse = r_enter;
  assign leave_pulse = r_leave;
  assign blocked1    = r_blocked[0];
  assign blocked2    = r_blocked[1];
  assign stuck1      = r_stuck[0];
  assign stuck2      = r_stuck[1];
  assign rejects     = r_rejects;

endmodule

// File: tb/tb_photocell_rx.sv
// tb/tb_photocell_rx.sv - scoreboard bench for photocell_rx
// Window-based reference model predicts pulses, blocked/stuck state and rejects.
module tb_photocell_rx;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int SMAX = 1000;

  logic clk = 1'b0, rst_n = 1'b0, ph1 = 1'b1, ph2 = 1'b1, full = 1'b0, empty = 1'b0;
  logic enter_pulse, leave_pulse, blocked1, blocked2, stuck1, stuck2;
  logic [3:0] rejects;

  always #5 clk = ~clk;

  photocell_rx #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .STUCK_MAX(SMAX)) dut (
    .FPGA_clk(clk), .reset(rst_n), .phcOne(ph1), .phcTwo(ph2), .full(full), .empty(empty),
    .enter_pulse(enter_pulse), .leave_pulse(leave_pulse), .blocked1(blocked1), .blocked2(blocked2),
    .stuck1(stuck1), .stuck2(stuck2), .rejects(rejects)
  );

  typedef struct {int cyc; bit en; bit lv;} exp_t;
  exp_t sb[$];
  exp_t e_cur;

  int errors = 0, checks = 0;
  int cyc = 0, base = 1;
  bit [1:0] hist [0:255];
  bit m_blk [2];
  int last_tr [2];
  int blk_edge [2];
  int ev_edge [2];
  int m_rej;
  int n_enter = 0, n_leave = 0, n_both = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // synchronized sample used at an edge: raw level SYNC edges earlier, clear before reset release
  function automatic bit s_at(int c, int k);
    bit [1:0] h;
    if (k < base) return 1'b1;
    h = hist[k & 255];
    return h[c];
  endfunction

  task automatic model_reset();
    base = cyc + 1;
    for (int c = 0; c < 2; c++) begin
      m_blk[c]    = 1'b0;
      last_tr[c]  = cyc;
      blk_edge[c] = 0;
      ev_edge[c]  = -100;
    end
    m_rej = 0;
    sb.delete();
  endtask

  task automatic model_edge();
    bit e0, e1, want, stable;
    exp_t x;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist[cyc & 255] = {ph2, ph1};
    e0 = (ev_edge[0] == cyc - 1);
    e1 = (ev_edge[1] == cyc - 1);
    x.cyc = cyc; x.en = 1'b0; x.lv = 1'b0;
    if (e0 && e1) begin
      x.en = 1'b1; x.lv = 1'b1;
    end else if (e0) begin
      if (!full) x.en = 1'b1;
      else if (m_rej < 15) m_rej++;
    end else if (e1) begin
      if (!empty) x.lv = 1'b1;
      else if (m_rej < 15) m_rej++;
    end
    if (x.en || x.lv) sb.push_back(x);
    // a level is accepted once the last DEB samples since the previous change all agree
    for (int c = 0; c < 2; c++) begin
      want = m_blk[c];
      stable = (cyc - DEB + 1 > last_tr[c]);
      for (int j = 0; j < DEB; j++)
        if (s_at(c, cyc - j - SYNC) != want) stable = 1'b0;
      if (stable) begin
        m_blk[c] = !m_blk[c];
        last_tr[c] = cyc;
        if (m_blk[c]) blk_edge[c] = cyc;
        else ev_edge[c] = cyc;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("stale_pulse_expectation", 0, 1);
      void'(sb.pop_front());
    end
    if (enter_pulse || leave_pulse || (sb.size() > 0 && sb[0].cyc == cyc)) begin
      e_cur.cyc = cyc; e_cur.en = 1'b0; e_cur.lv = 1'b0;
      if (sb.size() > 0 && sb[0].cyc == cyc) e_cur = sb.pop_front();
      chk("pulse_enter_leave", int'({enter_pulse, leave_pulse}), int'({e_cur.en, e_cur.lv}));
    end
    if (enter_pulse) n_enter++;
    if (leave_pulse) n_leave++;
    if (enter_pulse && leave_pulse) n_both++;
    chk("blocked", int'({blocked2, blocked1}), int'({m_blk[1], m_blk[0]}));
    chk("stuck", int'({stuck2, stuck1}),
        int'({m_blk[1] && (cyc - blk_edge[1] >= SMAX), m_blk[0] && (cyc - blk_edge[0] >= SMAX)}));
    chk("rejects", int'(rejects), m_rej);
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pass(int c, int lo, int hi);
    if (c == 0) ph1 = 1'b0; else ph2 = 1'b0;
    step(lo);
    if (c == 0) ph1 = 1'b1; else ph2 = 1'b1;
    step(hi);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_enter"}, int'(enter_pulse), 0);
    chk({tag, "_leave"}, int'(leave_pulse), 0);
    chk({tag, "_blocked"}, int'({blocked2, blocked1}), 0);
    chk({tag, "_stuck"}, int'({stuck2, stuck1}), 0);
    chk({tag, "_rejects"}, int'(rejects), 0);
  endtask

  int ne, nl, nb;
  int rem [2];

  initial begin
    model_reset();
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(3);

    // single entrance passage with exact latencies
    ph1 = 1'b0;
    step(5); chk("t1_blocked_early", int'(blocked1), 0);
    step(1); chk("t1_blocked_at6", int'(blocked1), 1);
    step(4); ph1 = 1'b1; ne = n_enter;
    step(6); chk("t1_enter_early", int'(enter_pulse), 0);
    step(1); chk("t1_enter_at7", int'(enter_pulse), 1);
    chk("t1_leave_quiet", int'(leave_pulse), 0);
    step(1); chk("t1_enter_width", int'(enter_pulse), 0);
    step(4); chk("t1_enter_count", n_enter - ne, 1);

    // short pulse rejected; glitch inside long block absorbed
    ne = n_enter;
    ph1 = 1'b0; step(3); ph1 = 1'b1; step(10);
    chk("t2_short_ignored", n_enter - ne, 0);
    ph1 = 1'b0; step(9); ph1 = 1'b1; step(1); ph1 = 1'b0; step(10); ph1 = 1'b1; step(12);
    chk("t2_one_enter", n_enter - ne, 1);

    // simultaneous release bypasses full/empty gating
    full = 1'b1; empty = 1'b0; nb = n_both;
    ph1 = 1'b0; ph2 = 1'b0; step(8); ph1 = 1'b1; ph2 = 1'b1; step(10);
    chk("t4_both_pulses", n_both - nb, 1);
    chk("t4_rejects_unchanged", int'(rejects), 0);

    // stuck beam
    full = 1'b0; ne = n_enter;
    ph1 = 1'b0; step(1005); ph1 = 1'b1;
    step(2); chk("t5_stuck_set", int'(stuck1), 1);
    step(10);
    chk("t5_stuck_clear", int'(stuck1), 0);
    chk("t5_blocked_clear", int'(blocked1), 0);
    chk("t5_enter_once", n_enter - ne, 1);

    // exit passages dropped while empty, rejects saturating
    empty = 1'b1; nl = n_leave;
    repeat (5) pass(1, 6, 8);
    step(4);
    chk("t3_rejects5", int'(rejects), 5);
    chk("t3_no_leave", n_leave - nl, 0);
    repeat (12) pass(1, 6, 8);
    step(4);
    chk("t3_rejects_sat", int'(rejects), 15);

    // asynchronous reset during release debounce
    empty = 1'b0; nl = n_leave;
    ph2 = 1'b0; step(8); ph2 = 1'b1; step(3);
    rst_n = 1'b0; model_reset(); #1;
    chk_all_zero("t6_async");
    step(3); rst_n = 1'b1; step(15);
    chk("t6_no_leave", n_leave - nl, 0);
    pass(1, 8, 10);
    chk("t6_leave_after", n_leave - nl, 1);

    // randomized beams and flags against the model
    rem[0] = $urandom_range(1, 12);
    rem[1] = $urandom_range(1, 12);
    for (int i = 0; i < 3000; i++) begin
      rem[0]--; rem[1]--;
      if (rem[0] == 0) begin ph1 = ~ph1; rem[0] = $urandom_range(1, 12); end
      if (rem[1] == 0) begin ph2 = ~ph2; rem[1] = $urandom_range(1, 12); end
      if ($urandom_range(0, 15) == 0) full = ~full;
      if ($urandom_range(0, 15) == 0) empty = ~empty;
      step(1);
    end
    ph1 = 1'b1; ph2 = 1'b1;
    step(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
